// File: rtl/cmd_dispatcher.sv
// Host command dispatcher: buffers well-formed commands in an in-order FIFO and
// presents the head command to its target bank with a one-hot valid/ready handshake.
module cmd_dispatcher #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_in,
    output logic        cmd_ready,
    output logic [7:0]  bank_cmd_valid,
    output logic [31:0] bank_cmd_out,
    output logic        bank_bl,
    output logic        bank_ap,
    input  logic [7:0]  bank_cmd_ready,
    output logic        cmd_error,
    output logic [4:0]  fifo_count
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENTRY_W = 34;
    localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t               state_q;
    logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     wr_ptr_d;
    logic [4:0]           count_q;
    logic [4:0]           count_d;
    logic [7:0]           bank_valid_q;
    logic [31:0]          bank_out_q;
    logic                 bank_bl_q;
    logic                 bank_ap_q;
    logic                 cmd_error_q;

    // Input command fields
    logic                 in_rw;
    logic [12:0]          in_row;
    logic                 in_bl;
    logic                 in_ap;
    logic [9:0]           in_col;
    logic [2:0]           in_bank;
    logic                 in_malformed;

    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 head_is_new;
    logic [ENTRY_W-1:0]   in_entry;
    logic [ENTRY_W-1:0]   head_entry;
    logic [7:0]           head_onehot;

    assign in_rw        = cmd_in[31];
    assign in_row       = cmd_in[29:17];
    assign in_bl        = cmd_in[15];
    assign in_ap        = cmd_in[13];
    assign in_col       = cmd_in[12:3];
    assign in_bank      = cmd_in[2:0];
    assign in_malformed = cmd_in[30] | cmd_in[16] | cmd_in[14];

    // Entries are stored already translated: {bl, ap, bank_command_t}
    assign in_entry = {in_bl, in_ap, in_rw, 1'b0, in_row, 4'b0000, in_col, in_bank};

    assign cmd_ready = ~rst & (count_q < DEPTH_CNT);
    assign accept    = cmd_valid & cmd_ready;
    assign push      = accept & ~in_malformed;
    assign pop       = |(bank_valid_q & bank_cmd_ready);

    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
    assign count_d  = count_q + {4'b0000, push} - {4'b0000, pop};

    // When the FIFO drains to nothing in the same cycle as a push, the new
    // command becomes the head before it is readable from the array.
    assign head_is_new = push & (count_q == {4'b0000, pop});
    assign head_entry  = head_is_new ? in_entry : mem_q[rd_ptr_d];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bank_decode
            assign head_onehot[gi] = (head_entry[2:0] == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_EMPTY;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            bank_valid_q <= '0;
            bank_out_q   <= '0;
            bank_bl_q    <= 1'b0;
            bank_ap_q    <= 1'b0;
            cmd_error_q  <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            cmd_error_q <= accept & in_malformed;
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        state_q      <= S_ISSUE;
                        bank_valid_q <= head_onehot;
                        bank_out_q   <= head_entry[31:0];
                        bank_bl_q    <= head_entry[33];
                        bank_ap_q    <= head_entry[32];
                    end
                end
                S_ISSUE: begin
                    if (pop) begin
                        if (count_q == 5'd1 && !push) begin
                            state_q      <= S_EMPTY;
                            bank_valid_q <= '0;
                            bank_out_q   <= '0;
                            bank_bl_q    <= 1'b0;
                            bank_ap_q    <= 1'b0;
                        end else begin
                            bank_valid_q <= head_onehot;
                            bank_out_q   <= head_entry[31:0];
                            bank_bl_q    <= head_entry[33];
                            bank_ap_q    <= head_entry[32];
                        end
                    end
                end
                default: begin
                    state_q      <= S_EMPTY;
                    bank_valid_q <= '0;
                end
            endcase
        end
    end

    assign bank_cmd_valid = bank_valid_q;
    assign bank_cmd_out   = bank_out_q;
    assign bank_bl        = bank_bl_q;
    assign bank_ap        = bank_ap_q;
    assign cmd_error      = cmd_error_q;
    assign fifo_count     = count_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Bench for cmd_dispatcher: a queue-based model of the command stream predicts
// every output; scenarios cover reset, fill, malformed drops, blocking and wrap.
module tb_cmd_dispatcher;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_in = '0;
    logic [7:0]  bank_cmd_ready = '0;
    logic        cmd_ready;
    logic [7:0]  bank_cmd_valid;
    logic [31:0] bank_cmd_out;
    logic        bank_bl;
    logic        bank_ap;
    logic        cmd_error;
    logic [4:0]  fifo_count;

    int total = 0;
    int bad = 0;
    logic [31:0] mq[$];
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    cmd_dispatcher #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_in         (cmd_in),
        .cmd_ready      (cmd_ready),
        .bank_cmd_valid (bank_cmd_valid),
        .bank_cmd_out   (bank_cmd_out),
        .bank_bl        (bank_bl),
        .bank_ap        (bank_ap),
        .bank_cmd_ready (bank_cmd_ready),
        .cmd_error      (cmd_error),
        .fifo_count     (fifo_count)
    );

    function automatic logic [31:0] mk(input logic rw, input logic [12:0] row, input logic bl,
                                       input logic ap, input logic [9:0] col, input logic [2:0] bank);
        return {rw, 1'b0, row, 1'b0, bl, 1'b0, ap, col, bank};
    endfunction

    function automatic logic is_bad(input logic [31:0] c);
        return c[30] | c[16] | c[14];
    endfunction

    function automatic logic [31:0] rand_cmd();
        logic [31:0] c;
        c = $urandom;
        return mk(c[31], c[29:17], c[15], c[13], c[12:3], c[2:0]);
    endfunction

    function automatic logic [31:0] xl(input logic [31:0] c);
        logic [13:0] row14;
        logic [13:0] col14;
        row14 = 14'(c[29:17]);
        col14 = 14'(c[12:3]);
        return {c[31], row14, col14, c[2:0]};
    endfunction

    function automatic logic [7:0] ev();
        logic [31:0] h;
        if (mq.size() == 0) return 8'h00;
        h = mq[0];
        return 8'h01 << h[2:0];
    endfunction

    function automatic logic [31:0] eo();
        if (mq.size() == 0) return 32'h0;
        return xl(mq[0]);
    endfunction

    function automatic logic ebl();
        logic [31:0] h;
        if (mq.size() == 0) return 1'b0;
        h = mq[0];
        return h[15];
    endfunction

    function automatic logic eap();
        logic [31:0] h;
        if (mq.size() == 0) return 1'b0;
        h = mq[0];
        return h[13];
    endfunction

    // Drives one cycle of inputs and advances the reference model across the edge.
    task automatic tick(input logic v, input logic [31:0] c, input logic [7:0] rdy);
        logic acc;
        logic pp;
        logic [31:0] h;
        cmd_valid = v;
        cmd_in = c;
        bank_cmd_ready = rdy;
        acc = v && !rst && (mq.size() < DEPTH);
        pp = 1'b0;
        h = '0;
        if (mq.size() > 0) begin
            h = mq[0];
            pp = rdy[h[2:0]];
        end
        @(posedge clk);
        if (rst) begin
            mq.delete();
            exp_err = 1'b0;
        end else begin
            if (pp) begin
                void'(mq.pop_front());
                $display("txn pop  bank=%0d cmd=%h", h[2:0], h);
            end
            if (acc) begin
                $display("txn push cmd=%h malformed=%0d", c, is_bad(c));
                if (!is_bad(c)) mq.push_back(c);
            end
            exp_err = acc && is_bad(c);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, rand_cmd(), 8'hFF);
            total++;
            if ({bank_cmd_valid, bank_cmd_out, bank_bl, bank_ap, cmd_error, fifo_count, cmd_ready} !== 49'h0) begin
                bad++;
                $display("FAIL reset_outputs: got valid=%h out=%h bl=%b ap=%b err=%b cnt=%0d rdy=%b, want all 0",
                         bank_cmd_valid, bank_cmd_out, bank_bl, bank_ap, cmd_error, fifo_count, cmd_ready);
            end
        end
        rst = 1'b0;
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_directed_read();
        logic [31:0] c;
        c = mk(1'b1, 13'h1ABC, 1'b1, 1'b1, 10'h155, 3'd5);
        tick(1'b1, c, 8'h00);
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({bank_cmd_valid, bank_cmd_out, bank_bl, bank_ap} !== {8'b0010_0000, 1'b1, 14'h1ABC, 14'h0155, 3'd5, 1'b1, 1'b1}) begin
                bad++;
                $display("FAIL directed_hold[%0d]: got valid=%h out=%h bl=%b ap=%b, want valid=20 out=%h bl=1 ap=1",
                         i, bank_cmd_valid, bank_cmd_out, bank_bl, bank_ap, {1'b1, 14'h1ABC, 14'h0155, 3'd5});
            end
            tick(1'b0, 32'h0, 8'h00);
        end
        tick(1'b0, 32'h0, 8'h20);
        total++;
        if ({bank_cmd_valid, bank_cmd_out, bank_bl, bank_ap, fifo_count} !== 47'h0) begin
            bad++;
            $display("FAIL directed_pop: got valid=%h out=%h cnt=%0d, want all 0", bank_cmd_valid, bank_cmd_out, fifo_count);
        end
    endtask

    task automatic test_full();
        logic [31:0] sent[$];
        logic [31:0] c;
        for (int i = 0; i < 5; i++) begin
            c = rand_cmd();
            total++;
            if (cmd_ready !== (i < DEPTH)) begin
                bad++;
                $display("FAIL full_ready[%0d]: got %b want %b", i, cmd_ready, (i < DEPTH));
            end
            tick(1'b1, c, 8'h00);
            if (i < DEPTH) sent.push_back(c);
            total++;
            if (fifo_count !== 5'((i < DEPTH) ? i + 1 : DEPTH)) begin
                bad++;
                $display("FAIL full_count[%0d]: got %0d want %0d", i, fifo_count, (i < DEPTH) ? i + 1 : DEPTH);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if (bank_cmd_out !== xl(sent[i])) begin
                bad++;
                $display("FAIL full_drain_order[%0d]: got %h want %h", i, bank_cmd_out, xl(sent[i]));
            end
            tick(1'b0, 32'h0, 8'hFF);
        end
        total++;
        if (fifo_count !== 5'd0 || bank_cmd_valid !== 8'h00) begin
            bad++;
            $display("FAIL full_drained: got cnt=%0d valid=%h want 0/00", fifo_count, bank_cmd_valid);
        end
    endtask

    task automatic test_malformed();
        logic [31:0] c;
        int bitpos;
        for (int k = 0; k < 3; k++) begin
            bitpos = (k == 0) ? 30 : (k == 1) ? 16 : 14;
            c = rand_cmd();
            c[bitpos] = 1'b1;
            total++;
            if (cmd_ready !== 1'b1) begin
                bad++;
                $display("FAIL malformed_ready[%0d]: got %b want 1", k, cmd_ready);
            end
            tick(1'b1, c, 8'hFF);
            total++;
            if ({cmd_error, fifo_count, bank_cmd_valid} !== {1'b1, 5'd0, 8'h00}) begin
                bad++;
                $display("FAIL malformed_drop[%0d]: got err=%b cnt=%0d valid=%h want 1/0/00",
                         k, cmd_error, fifo_count, bank_cmd_valid);
            end
            tick(1'b0, 32'h0, 8'h00);
            total++;
            if (cmd_error !== 1'b0) begin
                bad++;
                $display("FAIL malformed_pulse_width[%0d]: got %b want 0", k, cmd_error);
            end
        end
    endtask

    task automatic test_head_blocking();
        logic [31:0] c0;
        logic [31:0] c1;
        c0 = rand_cmd();
        c0[2:0] = 3'd2;
        c1 = rand_cmd();
        c1[2:0] = 3'd6;
        tick(1'b1, c0, 8'h00);
        tick(1'b1, c1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 32'h0, 8'b1111_1011);
            total++;
            if ({bank_cmd_valid, bank_cmd_out, fifo_count} !== {8'h04, xl(c0), 5'd2}) begin
                bad++;
                $display("FAIL hol_block[%0d]: got valid=%h out=%h cnt=%0d want 04/%h/2",
                         i, bank_cmd_valid, bank_cmd_out, fifo_count, xl(c0));
            end
        end
        tick(1'b0, 32'h0, 8'h04);
        total++;
        if ({bank_cmd_valid, bank_cmd_out, fifo_count} !== {8'h40, xl(c1), 5'd1}) begin
            bad++;
            $display("FAIL hol_next_head: got valid=%h out=%h cnt=%0d want 40/%h/1",
                     bank_cmd_valid, bank_cmd_out, fifo_count, xl(c1));
        end
        tick(1'b0, 32'h0, 8'h40);
        total++;
        if ({bank_cmd_valid, fifo_count} !== 13'h0) begin
            bad++;
            $display("FAIL hol_drain: got valid=%h cnt=%0d want 00/0", bank_cmd_valid, fifo_count);
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b1, rand_cmd(), 8'h00);
        tick(1'b1, rand_cmd(), 8'h00);
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, rand_cmd(), 8'hFF);
            total++;
            if ({fifo_count, bank_cmd_valid, bank_cmd_out, bank_bl, bank_ap} !== {5'd2, ev(), eo(), ebl(), eap()}) begin
                bad++;
                $display("FAIL b2b[%0d]: got cnt=%0d valid=%h out=%h bl=%b ap=%b want 2/%h/%h/%b/%b",
                         i, fifo_count, bank_cmd_valid, bank_cmd_out, bank_bl, bank_ap, ev(), eo(), ebl(), eap());
            end
        end
        tick(1'b0, 32'h0, 8'hFF);
        tick(1'b0, 32'h0, 8'hFF);
        total++;
        if (fifo_count !== 5'd0) begin
            bad++;
            $display("FAIL b2b_drain: got cnt=%0d want 0", fifo_count);
        end
    endtask

    task automatic test_random();
        logic [31:0] c;
        logic v;
        logic [7:0] rdy;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = rand_cmd();
            if ($urandom_range(0, 7) == 0) c[14] = 1'b1;
            if ($urandom_range(0, 15) == 0) c[30] = 1'b1;
            rdy = 8'($urandom) & 8'($urandom);
            tick(v, c, rdy);
            total++;
            if ({bank_cmd_valid, bank_cmd_out, bank_bl, bank_ap, cmd_error, fifo_count, cmd_ready} !==
                {ev(), eo(), ebl(), eap(), exp_err, 5'(mq.size()), (mq.size() < DEPTH)}) begin
                bad++;
                $display("FAIL random[%0d]: got valid=%h out=%h bl=%b ap=%b err=%b cnt=%0d rdy=%b want %h/%h/%b/%b/%b/%0d/%b",
                         i, bank_cmd_valid, bank_cmd_out, bank_bl, bank_ap, cmd_error, fifo_count, cmd_ready,
                         ev(), eo(), ebl(), eap(), exp_err, mq.size(), (mq.size() < DEPTH));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] c;
        for (int i = 0; i <= DEPTH; i++) tick(1'b0, 32'h0, 8'hFF);
        for (int i = 0; i < 3; i++) tick(1'b1, rand_cmd(), 8'h00);
        c = rand_cmd();
        c[16] = 1'b1;
        tick(1'b1, c, 8'h00);
        total++;
        if ({fifo_count, cmd_error} !== {5'd3, 1'b1}) begin
            bad++;
            $display("FAIL rstmid_setup: got cnt=%0d err=%b want 3/1", fifo_count, cmd_error);
        end
        rst = 1'b1;
        tick(1'b1, rand_cmd(), 8'hFF);
        total++;
        if ({bank_cmd_valid, bank_cmd_out, bank_bl, bank_ap, cmd_error, fifo_count, cmd_ready} !== 49'h0) begin
            bad++;
            $display("FAIL rstmid_outputs: got valid=%h out=%h err=%b cnt=%0d rdy=%b want all 0",
                     bank_cmd_valid, bank_cmd_out, cmd_error, fifo_count, cmd_ready);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({cmd_ready, fifo_count} !== {1'b1, 5'd0}) begin
            bad++;
            $display("FAIL rstmid_release: got rdy=%b cnt=%0d want 1/0", cmd_ready, fifo_count);
        end
        tick(1'b0, 32'h0, 8'hFF);
        total++;
        if ({bank_cmd_valid, fifo_count} !== 13'h0) begin
            bad++;
            $display("FAIL rstmid_lost: got valid=%h cnt=%0d want 00/0", bank_cmd_valid, fifo_count);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed_read();
        test_full();
        test_malformed();
        test_head_blocking();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmd_dispatcher.md
CMD_DISPATCHER -- requirements
Module: cmd_dispatcher

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: command FIFO entries, power of two, 2..16.
REQ-002 SHALL have port clk  input  1  the only clock; all logic samples on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-004 SHALL have port cmd_valid  input  1  host command present.
REQ-005 SHALL have port cmd_in  input  32  packed command_t, MSB first: r_w, none_0, row_addr[12:0], none_1, burst_length, none_2, auto_precharge, col_addr[9:0], bank_addr[2:0].
REQ-006 SHALL have port cmd_ready  output  1  dispatcher accepts cmd_in this cycle.
REQ-007 SHALL have port bank_cmd_valid  output  8  one-hot per-bank valid; bit index equals bank_addr.
REQ-008 SHALL have port bank_cmd_out  output  32  packed bank_command_t: r_w, row_addr[13:0], col_addr[13:0], bank_addr[2:0].
REQ-009 SHALL have port bank_bl  output  1  burst_length of the head command, 0=BL_4, 1=BL_8.
REQ-010 SHALL have port bank_ap  output  1  auto_precharge of the head command.
REQ-011 SHALL have port bank_cmd_ready  input  8  per-bank ready.
REQ-012 SHALL have port cmd_error  output  1  one-cycle pulse when a command is dropped as malformed.
REQ-013 SHALL have port fifo_count  output  5  number of stored commands.

Function
REQ-014 SHALL accept a command on any cycle where cmd_valid and cmd_ready are both 1.
REQ-015 SHALL drive cmd_ready = 1 exactly when fifo_count < FIFO_DEPTH; full blocks new commands even if a pop occurs in the same cycle.
REQ-016 SHALL treat as malformed any accepted command with none_0, none_1 or none_2 nonzero.
REQ-017 A malformed command SHALL be accepted, not stored, and SHALL raise cmd_error on the following cycle for exactly one cycle.
REQ-018 A well-formed command SHALL be stored in the FIFO in arrival order.
REQ-019 SHALL translate stored commands: row_addr zero-extended 13->14 bits, col_addr zero-extended 10->14 bits, r_w and bank_addr copied unchanged.
REQ-020 SHALL use a two-state FSM. S_EMPTY: all bank_cmd_valid bits are 0. S_ISSUE: exactly one bit, bank_addr of the FIFO head, is 1.
REQ-021 SHALL go S_EMPTY->S_ISSUE on a push when empty; S_ISSUE->S_EMPTY on a pop that leaves the FIFO empty with no simultaneous push; otherwise it holds its state.
REQ-022 SHALL take one cycle from acceptance into an empty FIFO (cycle N) to bank_cmd_valid (cycle N+1); a command never bypasses the FIFO combinationally.
REQ-023 SHALL pop the head when bank_cmd_ready[bank_addr] = 1 while its bank_cmd_valid bit is 1; ready bits of other banks SHALL be ignored.
REQ-024 SHALL hold bank_cmd_out, bank_bl, bank_ap and bank_cmd_valid stable while the head is unpopped (strict in-order, head-of-line blocking).
REQ-025 On push and pop in the same cycle, fifo_count SHALL be unchanged and the next head SHALL appear on the following cycle.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 When bank_cmd_valid is all 0, bank_cmd_out, bank_bl and bank_ap SHALL be 0.

Reset
REQ-028 While rst = 1: FSM = S_EMPTY, pointers = 0, fifo_count = 0, bank_cmd_valid = 0, bank_cmd_out = 0, bank_bl = 0, bank_ap = 0, cmd_error = 0, and cmd_ready = 0.
REQ-029 Reset asserted mid-operation SHALL discard all stored commands and any pending cmd_error pulse; cmd_ready SHALL return to 1 on the first cycle after rst deasserts.

Verification
REQ-030 Read, row 0x1ABC, col 0x155, bank 5, BL_8, AP=1, with all bank_cmd_ready = 0 -> next cycle: bank_cmd_valid = 8'b0010_0000, row 14'h1ABC, col 14'h0155, bank_bl = 1, bank_ap = 1; outputs held stable for 10 cycles.
REQ-031 Five well-formed commands on consecutive cycles with all ready = 0 and FIFO_DEPTH = 4 -> cmd_ready falls after the 4th; the 5th is not accepted; fifo_count = 4.
REQ-032 Command with none_1 = 1 -> accepted, cmd_error = 1 for exactly one cycle, fifo_count unchanged, no bank_cmd_valid.
REQ-033 Head targets bank 2, bank_cmd_ready = 8'b1111_1011 -> no pop; then ready[2] = 1 -> pop; next head appears the following cycle.
REQ-034 Continuous push and pop for 20 cycles with FIFO_DEPTH = 4 -> order preserved across pointer wrap, fifo_count constant.
REQ-035 rst pulsed with 3 commands stored -> all outputs 0 during reset, stored commands lost, cmd_ready = 1 the first cycle after release.
